// File: rtl/ifq_pkg.sv
// Shared constants for the instruction fetch queue: opcode field, HALT encoding,
// default geometry and the fetch stop-state encoding.
package ifq_pkg;

    localparam int OPCODE_W        = 4;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

    localparam int INST_CAP_DEF    = 20;
    localparam int INST_LEN_DEF    = 12;
    localparam int DATA_LEN_DEF    = 8;
    localparam int QUEUE_DEPTH_DEF = 4;

    // ST_HALT is only ever entered when HALT-stop support is compiled in.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers, synchronous clear and
// full/empty/count flags. Push while full and pop while empty are ignored.
module ifq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[PW-1:0]] <= wdata;
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: credit-limited ROM reads into ifq_fifo, redirect flush.
// Define IFQ_HALT_STOP_EN to stop fetching once a HALT (opcode 4'hF) word is queued.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int INST_CAP    = INST_CAP_DEF,
    parameter int INST_LEN    = INST_LEN_DEF,
    parameter int DATA_LEN    = DATA_LEN_DEF,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic                        redirect,
    input  logic [$clog2(INST_CAP):0]   redirect_pc,
    output logic                        rom_r_en,
    output logic [$clog2(INST_CAP):0]   rom_addr,
    input  logic [INST_LEN-1:0]         rom_data,
    input  logic                        deq,
    output logic                        valid,
    output logic [OPCODE_W-1:0]         opcode,
    output logic [DATA_LEN-1:0]         operand,
    output logic [$clog2(INST_CAP):0]   inst_pc,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(INST_CAP) + 1;
    localparam int EW = INST_LEN + AW;
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [AW-1:0] END_PC = AW'(INST_CAP);

    logic [AW-1:0]   fpc;
    logic [AW-1:0]   inflight_pc;
    logic            inflight;
    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic            issue;
    logic            push;
    logic            pop;
    logic            halt_push;
    logic            credit_ok;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head;

    assign push = inflight && !redirect;
    assign pop  = deq && valid && !redirect;

`ifdef IFQ_HALT_STOP_EN
    assign halt_push = push && (rom_data[INST_LEN-1 -: OPCODE_W] == OP_HALT);
`else
    assign halt_push = 1'b0;
`endif

    // A read is only issued if its word is guaranteed a slot when it returns.
    assign credit_ok = (int'(count) + int'(inflight)) < QUEUE_DEPTH;

    // rstn gates the strobe so no read escapes while reset is held with en high.
    assign issue = rstn && en && !redirect && (fpc < END_PC) &&
                   (state == ST_RUN) && !halt_push && credit_ok;

    assign rom_r_en = issue;
    assign rom_addr = fpc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fpc         <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fpc      <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc         <= fpc + 1'b1;
                inflight_pc <= fpc;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        if (redirect)       state_nxt = ST_RUN;
        else if (halt_push) state_nxt = ST_HALT;
    end

    ifq_fifo #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (redirect),
        .push  (push),
        .wdata ({rom_data, inflight_pc}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign valid   = !empty;
    assign opcode  = head[EW-1 -: OPCODE_W];
    assign operand = head[AW +: DATA_LEN];
    assign inst_pc = head[AW-1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the fetch rules.
module tb_inst_fetch_queue;
    import ifq_pkg::*;

    localparam int INST_CAP    = 20;
    localparam int INST_LEN    = 12;
    localparam int DATA_LEN    = 8;
    localparam int QUEUE_DEPTH = 4;
    localparam int AW          = $clog2(INST_CAP) + 1;
`ifdef IFQ_HALT_STOP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic                clk, rstn, en, redirect, deq;
    logic [AW-1:0]       redirect_pc, rom_addr, inst_pc;
    logic                rom_r_en, valid, full, empty;
    logic [INST_LEN-1:0] rom_data;
    logic [3:0]          opcode;
    logic [DATA_LEN-1:0] operand;

    inst_fetch_queue dut (
        .clk(clk), .rstn(rstn), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
        .rom_r_en(rom_r_en), .rom_addr(rom_addr), .rom_data(rom_data), .deq(deq),
        .valid(valid), .opcode(opcode), .operand(operand), .inst_pc(inst_pc),
        .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [INST_LEN-1:0] word; int pc; } ent_t;

    logic [INST_LEN-1:0] rom [INST_CAP];
    ent_t    mq[$];
    int      m_fpc, m_ifpc;
    bit      m_infl, m_halt;
    bit      pend_rd;
    int      pend_addr;
    int      checks, errors;
    int      s_rd, s_addr, s_valid, s_full, s_op, s_opnd, s_pc;
    int      rd_cnt, last_addr;
    bit      saw3;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc = 0; m_ifpc = 0; m_infl = 0; m_halt = 0;
        pend_rd = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = 1'b1; deq = 1'b0; redirect = 1'b0;
        #2;
        check("rst_rom_r_en", rom_r_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_valid", valid, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cyc(bit e, bit d, bit r, int rpc);
        bit   halt_now, x_issue;
        ent_t w;
        if (pend_rd && pend_addr < INST_CAP) rom_data = rom[pend_addr];
        else                                 rom_data = INST_LEN'($urandom);
        en = e; deq = d; redirect = r; redirect_pc = AW'(rpc);
        #2;
        halt_now = HALT_EN && m_infl && !r && (rom[m_ifpc][INST_LEN-1 -: 4] == OP_HALT);
        x_issue  = e && !r && (m_fpc < INST_CAP) && !m_halt && !halt_now &&
                   (mq.size() + int'(m_infl) < QUEUE_DEPTH);
        check("rom_r_en", rom_r_en, x_issue);
        if (x_issue) check("rom_addr", rom_addr, m_fpc);
        check("valid", valid, mq.size() != 0);
        check("full", full, mq.size() == QUEUE_DEPTH);
        check("empty", empty, mq.size() == 0);
        if (mq.size() != 0) begin
            check("opcode", opcode, mq[0].word[INST_LEN-1 -: 4]);
            check("operand", operand, mq[0].word[DATA_LEN-1:0]);
            check("inst_pc", inst_pc, mq[0].pc);
        end
        s_rd = rom_r_en; s_addr = rom_addr; s_valid = valid; s_full = full;
        s_op = opcode; s_opnd = operand; s_pc = inst_pc;
        if (rom_r_en) begin
            rd_cnt++; last_addr = rom_addr;
            if (rom_addr == 3) saw3 = 1;
        end
        pend_rd = rom_r_en; pend_addr = int'(rom_addr);
        if (r) begin
            mq.delete(); m_infl = 0; m_fpc = rpc; m_halt = 0;
        end else begin
            if (d && mq.size() != 0) void'(mq.pop_front());
            if (m_infl) begin
                w.word = rom[m_ifpc]; w.pc = m_ifpc;
                mq.push_back(w);
            end
            if (halt_now) m_halt = 1;
            m_infl = x_issue; m_ifpc = m_fpc;
            if (x_issue) m_fpc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_rom(bit allow_halt);
        logic [INST_LEN-1:0] w;
        for (int i = 0; i < INST_CAP; i++) begin
            w = INST_LEN'($urandom);
            if (!allow_halt && w[INST_LEN-1 -: 4] == OP_HALT) w[INST_LEN-1 -: 4] = 4'h0;
            rom[i] = w;
        end
    endtask

    initial begin
        checks = 0; errors = 0; rd_cnt = 0; last_addr = -1; saw3 = 0;
        rstn = 1'b0; en = 1'b0; deq = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rom_data = '0;
        fill_rom(0);
        rom[0] = 12'h312;
        #1; @(posedge clk); #1;
        do_reset();

        // First fetch latency and head decode
        cyc(1, 0, 0, 0);
        check("t1_rd", s_rd, 1);
        check("t1_addr", s_addr, 0);
        check("t1_valid_c1", s_valid, 0);
        cyc(1, 0, 0, 0);
        check("t1_valid_c2", s_valid, 0);
        cyc(1, 0, 0, 0);
        check("t1_valid_c3", s_valid, 1);
        check("t1_opcode", s_op, 3);
        check("t1_operand", s_opnd, 8'h12);
        check("t1_pc", s_pc, 0);

        // Fill without dequeue: exactly four reads
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        check("t2_reads", rd_cnt, 4);
        check("t2_last_addr", last_addr, 3);
        check("t2_full", s_full, 1);
        check("t2_no_rd", s_rd, 0);

        // One dequeue from full frees one credit
        cyc(1, 1, 0, 0);
        check("t3_pc_before", s_pc, 0);
        cyc(1, 0, 0, 0);
        check("t3_rd", s_rd, 1);
        check("t3_addr", s_addr, 4);
        check("t3_full", s_full, 0);
        check("t3_pc_after", s_pc, 1);

        // Redirect while the addr-4 word is returning
        cyc(1, 0, 1, 7);
        cyc(1, 0, 0, 0);
        check("t4_valid", s_valid, 0);
        check("t4_rd", s_rd, 1);
        check("t4_addr", s_addr, 7);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("t4_new_valid", s_valid, 1);
        check("t4_new_pc", s_pc, 7);

        // Last slot and past-end redirects
        cyc(1, 1, 1, 19);
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);
        check("t5_reads_19", rd_cnt, 1);
        check("t5_addr_19", last_addr, 19);
        cyc(1, 1, 1, 20);
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);
        check("t5_reads_20", rd_cnt, 0);

        // HALT word at addr 2
        rom[2] = 12'hF00;
        cyc(1, 1, 1, 0);
        rd_cnt = 0; saw3 = 0;
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
        check("t6_saw_addr3", saw3, !HALT_EN);
        check("t6_reads", rd_cnt, HALT_EN ? 3 : 10);
        check("t6_last_addr", last_addr, HALT_EN ? 2 : 9);

        // Randomized traffic with a mid-run reset
        fill_rom(1);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cyc(($urandom_range(0, 9) < 8), $urandom_range(0, 1),
                ($urandom_range(0, 19) == 0), $urandom_range(0, 26));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter INST_CAP, default 20, meaning the number of instruction slots in the program ROM.
REQ-002 SHALL have parameter INST_LEN, default 12, meaning the instruction word width.
REQ-003 SHALL have parameter DATA_LEN, default 8, meaning the operand field width (INST_LEN-4).
REQ-004 SHALL have parameter QUEUE_DEPTH, default 4, meaning prefetch queue entries; power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: the clock.
REQ-006 SHALL have port rstn, input, 1 bit: the reset; asynchronous, active-low.
REQ-007 SHALL have port en, input, 1 bit: prefetch enable.
REQ-008 SHALL have port redirect, input, 1 bit: flush and restart fetch at redirect_pc.
REQ-009 SHALL have port redirect_pc, input, $clog2(INST_CAP)+1 bits: the new fetch address.
REQ-010 SHALL have port rom_r_en, output, 1 bit: ROM read strobe.
REQ-011 SHALL have port rom_addr, output, $clog2(INST_CAP)+1 bits: ROM read address.
REQ-012 SHALL have port rom_data, input, INST_LEN bits: ROM word, valid exactly 1 cycle after rom_r_en.
REQ-013 SHALL have port deq, input, 1 bit: consumer pops the head entry.
REQ-014 SHALL have port valid, output, 1 bit: the head entry is present.
REQ-015 SHALL have port opcode, output, 4 bits: head instruction[INST_LEN-1:INST_LEN-4].
REQ-016 SHALL have port operand, output, DATA_LEN bits: head instruction[DATA_LEN-1:0].
REQ-017 SHALL have port inst_pc, output, $clog2(INST_CAP)+1 bits: the ROM address of the head entry.
REQ-018 SHALL have ports full and empty, outputs, 1 bit each: queue occupancy flags.

Function
REQ-019 SHALL keep fetch pointer fpc and in-flight flag inflight; issue a read (rom_r_en=1, rom_addr=fpc, fpc+1) when en, no redirect, fpc<INST_CAP, fetch not stopped, and occupancy+inflight<QUEUE_DEPTH.
REQ-020 SHALL push {rom_data, address} into the queue in the cycle after the read; read-to-valid latency is 2 cycles from en when the queue is empty.
REQ-021 SHALL update valid/opcode/operand/inst_pc combinationally from the head entry; outputs are don't-care when valid=0.
REQ-022 SHALL pop on deq&&valid; deq while empty is ignored, with no underflow.
REQ-023 SHALL allow a push and a pop in the same cycle, leaving occupancy unchanged.
REQ-024 SHALL stop issuing reads at fpc==INST_CAP (end of program) and remain idle until redirect or reset.
REQ-025 SHALL, on redirect, clear the queue (valid=0 in the next cycle), drop any in-flight ROM word, set fpc=redirect_pc, and clear the stop state; redirect overrides same-cycle deq, push and issue.
REQ-026 SHALL treat redirect_pc>=INST_CAP as end of program, issuing no read.
REQ-027 SHALL hold the queue contents while en=0; an in-flight word is still pushed.
REQ-028 SHALL never push when full; the credit rule in REQ-019 guarantees this.

Reset
REQ-029 SHALL, while rstn=0, asynchronously set fpc=0, inflight=0, queue pointers=0, rom_r_en=0, rom_addr=0, valid=0, empty=1, full=0, and clear the stop state.
REQ-030 SHALL, on reset during a fetch, discard the pending ROM word.

Configuration
REQ-031 SHALL, with IFQ_HALT_STOP_EN defined, set the stop state when a word with opcode 4'hF (HALT) is pushed; the stop state blocks further reads until redirect.
REQ-032 SHALL, without IFQ_HALT_STOP_EN, treat HALT like any other opcode and stop only at INST_CAP.

Structure
REQ-033 SHALL take OPCODE_W=4, OP_HALT=4'hF and the default widths from shared package ifq_pkg.
REQ-034 SHALL implement storage in sub-module ifq_fifo (parameterised circular buffer with full/empty flags).

Verification
REQ-035 Bench SHALL cover: reset, en=1, ROM[0]=12'h312, no deq -> rom_r_en at cycle 1, valid=1 at cycle 3, opcode=3, operand=8'h12, inst_pc=0.
REQ-036 Bench SHALL cover: en=1 held, no deq -> exactly 4 reads (addr 0-3), then full=1 and rom_r_en stays 0.
REQ-037 Bench SHALL cover: full queue, deq held 1 cycle -> one read at addr 4 issued in the next cycle, full drops, and inst_pc goes 0->1.
REQ-038 Bench SHALL cover: redirect=1 with redirect_pc=7 while a read is in flight -> valid=0 next cycle, first new read at addr 7, and the stale word never appears.
REQ-039 Bench SHALL cover: redirect_pc=19 with INST_CAP=20 -> one read at 19, then no reads; redirect_pc=20 -> no reads at all.
REQ-040 Bench SHALL cover: with IFQ_HALT_STOP_EN defined and ROM[2]=12'hF00 -> reads stop after addr 2 despite free space; without the macro -> reads continue at addr 3.
